alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU (add/sub/and/or). Accepts operation requests on valid/ready handshakes, grants round-robin, drives the ALU operands and opcode for one cycle, registers the ALU result and zero flag, and returns them on a per-requester response handshake. It lets the PC-increment path (requester 0) and the execute stage (requester 1) share one ALU instance in the CPU datapath.

## Interface
- WIDTH, 32: operand/result width; must match the ALU.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid, req1_valid  in  1  request present; held with operands stable until accepted.
- req0_ready, req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands.
- req0_op, req1_op  in  4  opcode: 0000 add, 1000 sub, 0111 and, 0110 or.
- rsp0_valid, rsp1_valid  out  1  response available.
- rsp0_ready, rsp1_ready  in  1  requester consumes response.
- rsp0_data, rsp1_data  out  WIDTH  registered result.
- rsp0_zero, rsp1_zero  out  1  registered ALU zero flag.
- rsp0_err, rsp1_err  out  1  opcode was illegal.
- alu_a, alu_b  out  WIDTH  to ALU operands.
- alu_op  out  4  to ALU opcode.
- alu_out  in  WIDTH  from ALU result.
- alu_zero  in  1  from ALU zero.

## Operation
- States: IDLE, EXEC, RESP. Reset -> IDLE.
- IDLE: if no valid, stay. If exactly one reqN_valid, grant N. If both, grant the priority holder. reqN_ready = 1 combinationally for the granted N only. On acceptance: latch a, b, op, grant index; set err_q = (op not in {0000,1000,0111,0110}); -> EXEC.
- EXEC: alu_a/alu_b driven from latched operands. alu_op = latched op, or 0000 if err_q. Capture alu_out, alu_zero into result registers -> RESP.
- RESP: rspN_valid = 1 for the granted N; data/zero/err from registers. If err_q: data = 0, zero = 0, err = 1. When rspN_ready: -> IDLE; priority passes to the other requester.
- Priority: reset value = requester 0. Updated only on response completion, so each completed transaction yields priority to the other requester.
- Outside EXEC: alu_a = 0, alu_b = 0, alu_op = 0000.
- No request is accepted in EXEC or RESP; both ready outputs are 0.
- rsp outputs for the non-granted requester: valid 0, data/zero/err 0.
- Result width: full WIDTH; add/sub wrap modulo 2^WIDTH with no carry/overflow output.
- Reset asserted in any state: return to IDLE and drop any in-flight transaction with no response. Priority -> 0. All outputs -> 0.

## Timing
- Request accepted in cycle T (valid and ready high at edge T).
- EXEC in cycle T+1; ALU path is combinational within that cycle.
- rspN_valid rises at T+2.
- If rspN_ready is high at T+2, the next acceptance is at T+3 at the earliest.
- Peak throughput: one operation per 3 cycles.
- rspN_valid stays high, with data stable, until rspN_ready. Back-pressure is unbounded.
- reqN_ready depends only on state, priority and valids, never on rsp*_ready. There is no combinational path from rsp_ready to req_ready.
- Reset values: state IDLE, priority 0, all outputs 0.

## Test plan
- Reset and idle: hold rst 2 cycles with both valids high. Required: all outputs 0 during reset. First cycle after release: req0_ready = 1, req1_ready = 0.
- Single add: req0 a=5, b=7, op=0000 at T. Required: alu_op = 0000 and alu_a = 5 at T+1; rsp0_valid at T+2 with data = 12, zero = 0, err = 0.
- Contention and fairness: both valid continuously, rsp ready tied high. Req1 op=1000 with a=b=9. Required:
  - grants alternate 0, 1, 0, 1, one every 3 cycles;
  - req1 response has data = 0, zero = 1.
- Back-pressure: req1 op=0110 with a=0xF0, b=0x0F, rsp1_ready low for 5 cycles. Required: rsp1_valid held with data = 0xFF; no new acceptance until the cycle after rsp1_ready rises.
- Illegal op: req0 op=0011. Required: alu_op = 0000 in EXEC; rsp0 err = 1, data = 0, zero = 0. Priority then passes to requester 1.
- Reset mid-operation: assert rst in EXEC and, separately, in RESP. Required: no response is produced. Next cycle is IDLE with priority 0. A pending req1 alone is granted immediately after.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one 32-bit ALU (add/sub/and/or).
// Requests are granted round-robin. The granted operands go to the ALU for
// one cycle, and the registered result is returned on a per-requester
// response handshake. Requester 0 is the PC-increment path and requester 1
// is the execute stage.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp0_zero,
    output logic             rsp1_zero,
    output logic             rsp0_err,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             gnt_q;
    logic             err_q;
    logic             prio_q;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_op;
    logic             sel_illegal;
    logic             rsp_done;
    logic             in_exec;
    logic             in_resp;

    // Grant decision: only in IDLE; a lone valid wins, a tie goes to the priority holder
    always_comb begin
        grant0      = 1'b0;
        grant1      = 1'b0;
        if (state == IDLE && !rst) begin
            grant0 = req0_valid && (!req1_valid || !prio_q);
            grant1 = req1_valid && (!req0_valid ||  prio_q);
        end
        accept      = grant0 || grant1;
        sel_a       = grant1 ? req1_a  : req0_a;
        sel_b       = grant1 ? req1_b  : req0_b;
        sel_op      = grant1 ? req1_op : req0_op;
        sel_illegal = !(sel_op == OP_ADD || sel_op == OP_SUB ||
                        sel_op == OP_AND || sel_op == OP_OR);
        rsp_done    = (state == RESP) && (gnt_q ? rsp1_ready : rsp0_ready);
    end

    // Sequencer: latch the request, run the ALU for one cycle, hold the response until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            gnt_q  <= 1'b0;
            err_q  <= 1'b0;
            prio_q <= 1'b0;
            data_q <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        op_q  <= sel_op;
                        gnt_q <= grant1;
                        err_q <= sel_illegal;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    data_q <= err_q ? '0 : alu_out;
                    zero_q <= err_q ? 1'b0 : alu_zero;
                    state  <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        prio_q <= ~gnt_q;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output drive: ALU port only in EXEC, response only toward the granted requester, all quiet in reset
    always_comb begin
        in_exec    = (state == EXEC) && !rst;
        in_resp    = (state == RESP) && !rst;
        req0_ready = grant0;
        req1_ready = grant1;
        alu_a      = in_exec ? a_q : '0;
        alu_b      = in_exec ? b_q : '0;
        alu_op     = (in_exec && !err_q) ? op_q : OP_ADD;
        rsp0_valid = in_resp && !gnt_q;
        rsp1_valid = in_resp &&  gnt_q;
        rsp0_data  = rsp0_valid ? data_q : '0;
        rsp1_data  = rsp1_valid ? data_q : '0;
        rsp0_zero  = rsp0_valid && zero_q;
        rsp1_zero  = rsp1_valid && zero_q;
        rsp0_err   = rsp0_valid && err_q;
        rsp1_err   = rsp1_valid && err_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_zero;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   gnt_ids[$];
    int   gnt_cyc[$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
        .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to measure grant spacing
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the shared ALU
    always_comb begin
        case (alu_op)
            4'b0000: alu_out = alu_a + alu_b;
            4'b1000: alu_out = alu_a - alu_b;
            4'b0111: alu_out = alu_a & alu_b;
            4'b0110: alu_out = alu_a | alu_b;
            default: alu_out = 32'h0;
        endcase
        alu_zero = (alu_out == 32'h0);
    end

    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            4'b0000: e.data = a + b;
            4'b1000: e.data = a - b;
            4'b0111: e.data = a & b;
            4'b0110: e.data = a | b;
            default: begin
                e.data = 32'h0;
                e.err  = 1'b1;
            end
        endcase
        e.zero = !e.err && (e.data == 32'h0);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic checkRsp(input logic id, input logic [31:0] data, input logic zero, input logic err);
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("unexpected_rsp", 64'(id) + 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            checkOutput("rsp_id",   64'(id),   64'(e.id));
            checkOutput("rsp_data", 64'(data), 64'(e.data));
            checkOutput("rsp_zero", 64'(zero), 64'(e.zero));
            checkOutput("rsp_err",  64'(err),  64'(e.err));
        end
    endtask

    // Monitor: push expectations on acceptance, compare on response handshake, flush on reset
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_a, req0_b, req0_op));
                gnt_ids.push_back(0);
                gnt_cyc.push_back(cyc);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_a, req1_b, req1_op));
                gnt_ids.push_back(1);
                gnt_cyc.push_back(cyc);
            end
            if (rsp0_valid && rsp0_ready) checkRsp(1'b0, rsp0_data, rsp0_zero, rsp0_err);
            if (rsp1_valid && rsp1_ready) checkRsp(1'b1, rsp1_data, rsp1_zero, rsp1_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
    endtask

    task automatic waitReady(input int n, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) seen = 1'b1;
        end
        if (!seen) checkOutput("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDrain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req1_valid = 1'b1;
        req1_a = 32'h0; req1_b = 32'h0; req1_op = 4'b0000;
        applyStimulus(0, 32'd5, 32'd7, 4'b0000);

        // Reset with both valids high: everything must read zero
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset_flags", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                                             rsp0_zero, rsp1_zero, rsp0_err, rsp1_err}), 64'd0);
            checkOutput("reset_rsp_data", {rsp0_data, rsp1_data}, 64'd0);
            checkOutput("reset_alu_ab", {alu_a, alu_b}, 64'd0);
            checkOutput("reset_alu_op", 64'(alu_op), 64'd0);
        end
        tick();
        rst = 1'b0;

        // First idle cycle: requester 0 holds priority; single add 5+7
        @(negedge clk);
        checkOutput("ready_after_reset", 64'({req0_ready, req1_ready}), 64'b10);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checkOutput("exec_alu_op", 64'(alu_op), 64'd0);
        checkOutput("exec_alu_ab", {alu_a, alu_b}, {32'd5, 32'd7});
        checkOutput("exec_no_rsp", 64'(rsp0_valid), 64'd0);
        @(negedge clk);
        checkOutput("rsp_latency", 64'(rsp0_valid), 64'd1);
        waitDrain(10);

        // Contention: reset priority to 0, both valid, grants must alternate every 3 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gnt_ids.delete();
        gnt_cyc.delete();
        applyStimulus(0, 32'd3, 32'd4, 4'b0000);
        applyStimulus(1, 32'd9, 32'd9, 4'b1000);
        for (int i = 0; i < 40 && gnt_ids.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("grant_count", 64'(gnt_ids.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < gnt_ids.size(); i++)
            checkOutput("grant_order", 64'(gnt_ids[i]), 64'(i % 2));
        for (int i = 1; i < 4 && i < gnt_cyc.size(); i++)
            checkOutput("grant_spacing", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd3);
        waitDrain(20);

        // Back-pressure on requester 1 while requester 0 waits
        rsp1_ready = 1'b0;
        applyStimulus(1, 32'hF0, 32'h0F, 4'b0110);
        waitReady(1, 10);
        tick();
        req1_valid = 1'b0;
        applyStimulus(0, 32'd1, 32'd1, 4'b0000);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
            checkOutput("bp_rsp1_data", 64'(rsp1_data), 64'hFF);
            checkOutput("bp_req0_blocked", 64'(req0_ready), 64'd0);
        end
        tick();
        rsp1_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_no_accept", 64'(req0_ready), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("bp_accept_after", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        waitDrain(10);

        // Illegal opcode from requester 0: ALU sees add, response flags error
        applyStimulus(0, 32'd5, 32'd6, 4'b0011);
        waitReady(0, 10);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checkOutput("illegal_alu_op", 64'(alu_op), 64'd0);
        checkOutput("illegal_alu_a", 64'(alu_a), 64'd5);
        waitDrain(10);
        applyStimulus(0, 32'd1, 32'd1, 4'b0000);
        applyStimulus(1, 32'd1, 32'd2, 4'b0000);
        @(negedge clk);
        checkOutput("prio_after_illegal", 64'({req0_ready, req1_ready}), 64'b01);
        tick();
        req1_valid = 1'b0;
        waitReady(0, 15);
        tick();
        req0_valid = 1'b0;
        waitDrain(10);

        // Reset during EXEC with priority at 1: transaction dropped, priority back to 0
        applyStimulus(1, 32'd2, 32'd2, 4'b0000);
        waitReady(1, 10);
        tick();
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 32'd4, 32'd4, 4'b0000);
        applyStimulus(1, 32'd7, 32'd1, 4'b1000);
        @(negedge clk);
        checkOutput("prio_after_reset_exec", 64'({req0_ready, req1_ready}), 64'b10);
        checkOutput("no_rsp_after_reset_exec", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        tick();
        req0_valid = 1'b0;
        waitReady(1, 15);
        tick();
        req1_valid = 1'b0;
        waitDrain(10);

        // Reset during RESP: response vanishes, lone pending req1 granted right after
        rsp0_ready = 1'b0;
        applyStimulus(0, 32'd8, 32'd8, 4'b0000);
        waitReady(0, 10);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("resp_before_reset", 64'(rsp0_valid), 64'd1);
        tick();
        rst = 1'b1;
        applyStimulus(1, 32'd10, 32'd3, 4'b1000);
        @(negedge clk);
        checkOutput("reset_in_resp_outputs", 64'({rsp0_valid, req1_ready, rsp0_data}), 64'd0);
        tick();
        rst = 1'b0;
        rsp0_ready = 1'b1;
        @(negedge clk);
        checkOutput("req1_after_reset", 64'({req1_ready, rsp0_valid}), 64'b10);
        tick();
        req1_valid = 1'b0;
        waitDrain(10);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
